// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle fetch/decode/execute controller owning PC, IR and register-window pointer
module alu_seq_ctrl #(
  parameter logic [11:0] RESET_PC  = 12'h000,
  parameter logic [1:0]  RESET_WND = 2'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic        mem_req,
  output logic        mem_we,
  output logic [11:0] mem_addr,
  output logic [11:0] pc,
  output logic [4:0]  alu_op,
  output logic        alu_a_imm,
  output logic [15:0] imm,
  output logic [1:0]  rf_rs,
  output logic        rf_we,
  output logic        rf_wsrc,
  output logic [1:0]  wnd,
  output logic        illegal
);
  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] WB     = 3'd3;
  localparam logic [2:0] MEM    = 3'd4;
  localparam logic [4:0] NOP_OP = 5'd10;
  logic [2:0]  state_q, state_d;
  logic [11:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [1:0]  wnd_q, wnd_d;
  logic [2:0]  op;
  logic [3:0]  func;
  logic        is_ls, is_jmp, is_br, is_r, is_i, r_alu, r_nop, r_wnd, bad, held;
  assign op     = ir_q[15:13];
  assign func   = ir_q[3:0];
  assign is_ls  = op[2:1] == 2'b00;
  assign is_jmp = op == 3'b010;
  assign is_br  = op == 3'b100;
  assign is_r   = op == 3'b110;
  assign is_i   = op == 3'b111;
  assign r_alu  = is_r && func < 4'd6;
  assign r_nop  = is_r && func == 4'd6;
  assign r_wnd  = is_r && func[3:2] == 2'b10;
  assign bad    = op == 3'b011 || op == 3'b101 || (is_r && (func == 4'd7 || func[3:2] == 2'b11));
  assign held   = state_q == EXEC || state_q == WB || state_q == MEM;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    wnd_d     = wnd_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 12'h000;
    alu_op    = NOP_OP;
    rf_we     = 1'b0;
    rf_wsrc   = 1'b0;
    illegal   = 1'b0;
    alu_a_imm = held && is_i;
    rf_rs     = (held && !is_i) ? ir_q[12:11] : 2'd0;
    imm       = held ? {8'h00, ir_q[7:0]} : 16'h0000;
    pc        = pc_q;
    wnd       = wnd_q;
    case (state_q)
      FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata;
          pc_d    = pc_q + 12'd1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        illegal = bad;
        pc_d    = is_jmp ? ir_q[11:0] : pc_q;
        wnd_d   = r_wnd ? func[1:0] : wnd_q;
        state_d = is_ls ? MEM : (is_br || is_i || r_alu) ? EXEC : FETCH;
      end
      EXEC: begin
        alu_op  = is_br ? 5'd3 : is_i ? 5'd15 + {3'b000, ir_q[12:11]} : {1'b0, func} + 5'd4;
        state_d = WB;
      end
      WB: begin
        rf_we   = !is_br;
        pc_d    = (is_br && alu_zero) ? {1'b0, ir_q[10:0]} : pc_q;
        state_d = FETCH;
      end
      MEM: begin
        mem_req  = 1'b1;
        mem_we   = op[0];
        mem_addr = ir_q[11:0];
        rf_we    = mem_ready && !op[0];
        rf_wsrc  = mem_ready && !op[0];
        state_d  = mem_ready ? FETCH : MEM;
      end
      default: state_d = FETCH;
    endcase
    // Reset forces every output quiet so an abandoned transaction has no side effect
    if (rst) begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = 12'h000;
      alu_op    = NOP_OP;
      rf_we     = 1'b0;
      rf_wsrc   = 1'b0;
      illegal   = 1'b0;
      alu_a_imm = 1'b0;
      rf_rs     = 2'd0;
      imm       = 16'h0000;
      pc        = RESET_PC;
      wnd       = RESET_WND;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 16'h0000;
      wnd_q   <= RESET_WND;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      wnd_q   <= wnd_d;
    end
  end
endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: instruction-level reference model driving directed and random programs into alu_seq_ctrl
module tb_alu_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] mem_rdata;
  logic        mem_ready;
  logic        alu_zero;
  logic        mem_req, mem_we, alu_a_imm, rf_we, rf_wsrc, illegal;
  logic [11:0] mem_addr, pc;
  logic [4:0]  alu_op;
  logic [15:0] imm;
  logic [1:0]  rf_rs, wnd;
  int          n_chk = 0;
  int          n_err = 0;
  logic [11:0] mpc;
  logic [1:0]  mwnd;
  alu_seq_ctrl dut (
    .clk(clk), .rst(rst), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .alu_zero(alu_zero),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .pc(pc), .alu_op(alu_op),
    .alu_a_imm(alu_a_imm), .imm(imm), .rf_rs(rf_rs), .rf_we(rf_we), .rf_wsrc(rf_wsrc),
    .wnd(wnd), .illegal(illegal)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h pc_model=%0h", tag, got, exp, mpc);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_fetch(input logic [15:0] instr, input int sf);
    for (int i = 0; i <= sf; i++) begin
      mem_ready = (i == sf);
      mem_rdata = mem_ready ? instr : 16'($urandom);
      alu_zero  = 1'($urandom);
      #1;
      check("fetch_req", mem_req, 1);
      check("fetch_we", mem_we, 0);
      check("fetch_addr", mem_addr, mpc);
      check("fetch_pc", pc, mpc);
      check("fetch_wnd", wnd, mwnd);
      check("fetch_rfwe", rf_we, 0);
      check("fetch_ill", illegal, 0);
      step();
    end
    mpc = mpc + 12'd1;
  endtask
  // Classes: 0 memory, 1 ALU/branch, 2 two-cycle (jump, window, nop, illegal)
  task automatic run_instr(input logic [15:0] instr, input int sf, input int sm, input logic z);
    logic [2:0] op;
    logic [3:0] f;
    int         cls;
    logic [4:0] eop;
    logic       ill;
    op  = instr[15:13];
    f   = instr[3:0];
    ill = 0;
    eop = 5'd10;
    cls = 2;
    case (op)
      3'd0, 3'd1: cls = 0;
      3'd4: begin cls = 1; eop = 5'd3; end
      3'd6: begin
        if (f <= 5) begin cls = 1; eop = 5'(f + 4); end
        else if (f != 6 && !(f >= 8 && f <= 11)) ill = 1;
      end
      3'd7: begin cls = 1; eop = 5'(15 + instr[12:11]); end
      3'd3, 3'd5: ill = 1;
      default: ;
    endcase
    do_fetch(instr, sf);
    mem_ready = 1'($urandom);
    #1;
    check("dec_req", mem_req, 0);
    check("dec_ill", illegal, ill);
    check("dec_rfwe", rf_we, 0);
    check("dec_op", alu_op, 10);
    step();
    if (op == 3'd2) mpc = instr[11:0];
    if (op == 3'd6 && f >= 8 && f <= 11) mwnd = 2'(f - 8);
    if (cls == 1) begin
      mem_ready = 1'($urandom);
      #1;
      check("ex_op", alu_op, eop);
      check("ex_rs", rf_rs, op == 3'd7 ? 2'd0 : instr[12:11]);
      check("ex_aimm", alu_a_imm, op == 3'd7);
      check("ex_imm", imm, {8'h00, instr[7:0]});
      check("ex_rfwe", rf_we, 0);
      check("ex_req", mem_req, 0);
      step();
      alu_zero = z;
      #1;
      check("wb_op", alu_op, 10);
      check("wb_rfwe", rf_we, op != 3'd4);
      check("wb_wsrc", rf_wsrc, 0);
      check("wb_req", mem_req, 0);
      step();
      if (op == 3'd4 && z) mpc = {1'b0, instr[10:0]};
    end else if (cls == 0) begin
      for (int i = 0; i <= sm; i++) begin
        mem_ready = (i == sm);
        #1;
        check("mem_req", mem_req, 1);
        check("mem_addr", mem_addr, instr[11:0]);
        check("mem_we", mem_we, op == 3'd1);
        check("mem_rfwe", rf_we, mem_ready && op == 3'd0);
        if (mem_ready && op == 3'd0) check("mem_wsrc", rf_wsrc, 1);
        step();
      end
    end
  endtask
  initial begin
    rst = 1;
    mem_ready = 1;
    mem_rdata = 16'h0;
    alu_zero = 0;
    mpc = 12'h000;
    mwnd = 2'd0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_req", mem_req, 0);
      check("rst_op", alu_op, 10);
      check("rst_pc", pc, 12'h000);
      check("rst_wnd", wnd, 2'd0);
      check("rst_rfwe", rf_we, 0);
      check("rst_ill", illegal, 0);
      step();
    end
    rst = 0;
    run_instr(16'hC0E1, 0, 0, 0);
    run_instr(16'hC8E1, 0, 0, 0);
    run_instr(16'h8805, 0, 0, 1);
    run_instr(16'h8805, 0, 0, 0);
    run_instr(16'h0123, 0, 3, 0);
    run_instr(16'h2456, 1, 2, 0);
    run_instr(16'hC00A, 0, 0, 0);
    run_instr(16'h6000, 0, 0, 0);
    run_instr(16'hC00F, 0, 0, 0);
    run_instr(16'hE805, 2, 0, 0);
    run_instr(16'h4FFF, 0, 0, 0);
    run_instr(16'hC006, 0, 0, 0);
    check("pc_wrap", pc, 12'h000);
    do_fetch(16'h0123, 0);
    mem_ready = 0;
    #1;
    check("dec_pre_rst", mem_req, 0);
    step();
    #1;
    check("mem_pre_rst", mem_req, 1);
    rst = 1;
    #1;
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_rfwe", rf_we, 0);
    check("rst_mid_pc", pc, 12'h000);
    check("rst_mid_op", alu_op, 10);
    step();
    rst = 0;
    mpc = 12'h000;
    mwnd = 2'd0;
    for (int n = 0; n < 400; n++)
      run_instr(16'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 1'($urandom));
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
